// File: rtl/line_store_server.sv
`default_nettype none
// ============================================================================
//  Module      : line_store_server
//  Description : Line buffer for the slice controller. It loads a block of
//                lines from upstream, serves lines one per request with
//                in-place write-back, and then streams the updated block
//                downstream. It also owns line counting and end-of-block
//                signalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_store_server #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              ld_valid,
  input  logic [LINE_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              start,
  input  logic              readLine,
  output logic [LINE_W-1:0] line,
  output logic              line_valid,
  output logic              last_line,
  input  logic              write,
  input  logic [LINE_W-1:0] wdata,
  input  logic              finish,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              overrun,
  output logic [AW:0]       count
);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

  // Count value that marks the last physical location being filled.
  localparam logic [AW:0] c_full = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_one  = (AW+1)'(1);

  state_t              state_q, state_d;
  logic [AW:0]         count_q, count_d;
  logic [AW:0]         rp_q, rp_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic [AW-1:0]       op_q, op_d;
  logic                delivered_q, delivered_d;  // a line has been served this block
  logic                start_q, start_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                line_valid_q, line_valid_d;
  logic                last_line_q, last_line_d;
  logic                overrun_q, overrun_d;

  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W-1:0]   mem [DEPTH];

  logic [AW:0]         count_m1;
  logic                dump_last;

  assign count_m1  = count_q - c_one;
  assign dump_last = ({1'b0, op_q} == count_m1);

  // Outputs that follow the state directly; the dump beat is held while the
  // consumer stalls because op and memory do not change in DUMP.
  assign ld_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid  = (state_q == DUMP);
  assign out_data   = (state_q == DUMP) ? mem[op_q] : '0;
  assign out_last   = (state_q == DUMP) && dump_last;
  assign start      = start_q;
  assign line       = line_q;
  assign line_valid = line_valid_q;
  assign last_line  = last_line_q;
  assign overrun    = overrun_q;
  assign count      = count_q;

  // Next-state, pointer and memory-port logic for the load/serve/dump cycle.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rp_d         = rp_q;
    wp_d         = wp_q;
    op_d         = op_q;
    delivered_d  = delivered_q;
    start_d      = 1'b0;
    line_d       = '0;
    line_valid_d = 1'b0;
    last_line_d  = 1'b0;
    overrun_d    = overrun_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = ld_data;

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          count_d   = c_one;
          if (ld_last) begin
            state_d     = SERVE;
            start_d     = 1'b1;
            rp_d        = '0;
            delivered_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = count_q[AW-1:0];
          count_d   = count_q + 1'b1;
          // Filling the final location ends the block even without ld_last.
          if (ld_last || (count_q == c_full)) begin
            state_d     = SERVE;
            start_d     = 1'b1;
            rp_d        = '0;
            delivered_d = 1'b0;
            if (!ld_last) begin
              overrun_d = 1'b1;
            end
          end
        end
      end

      SERVE: begin
        if (readLine) begin
          if (rp_q < count_q) begin
            line_d       = mem[rp_q[AW-1:0]];
            line_valid_d = 1'b1;
            last_line_d  = (rp_q == count_m1);
            wp_d         = rp_q[AW-1:0];
            rp_d         = rp_q + 1'b1;
            delivered_d  = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        // Write-back targets the previously delivered line, never the one
        // being read this cycle, so both can proceed together.
        if (write) begin
          if (delivered_q) begin
            mem_we    = 1'b1;
            mem_waddr = wp_q;
            mem_wdata = wdata;
          end else begin
            overrun_d = 1'b1;
          end
        end
        if (finish) begin
          state_d = DUMP;
          op_d    = '0;
        end
      end

      DUMP: begin
        if (out_ready) begin
          if (dump_last) begin
            state_d = IDLE;
            count_d = '0;
            op_d    = '0;
          end else begin
            op_d = op_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rp_q         <= '0;
      wp_q         <= '0;
      op_q         <= '0;
      delivered_q  <= 1'b0;
      start_q      <= 1'b0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      last_line_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rp_q         <= rp_d;
      wp_q         <= wp_d;
      op_q         <= op_d;
      delivered_q  <= delivered_d;
      start_q      <= start_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      last_line_q  <= last_line_d;
      overrun_q    <= overrun_d;
    end
  end

  // Line storage; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_store_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_store_server
//  Description : Self-checking bench for line_store_server using directed
//                vector tables plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_store_server;

  localparam int LINE_W = 25;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  typedef struct packed {
    logic              ld_ready;
    logic              start;
    logic              line_valid;
    logic [LINE_W-1:0] line;
    logic              last_line;
    logic              out_valid;
    logic [LINE_W-1:0] out_data;
    logic              out_last;
    logic              overrun;
    logic [AW:0]       count;
  } outs_t;

  typedef struct {
    logic              ld_valid;
    logic [LINE_W-1:0] ld_data;
    logic              ld_last;
    logic              rd;
    logic              wr;
    logic [LINE_W-1:0] wdata;
    logic              fin;
    logic              ordy;
    outs_t             exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic [LINE_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              start;
  logic              readLine;
  logic [LINE_W-1:0] line;
  logic              line_valid;
  logic              last_line;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic              finish;
  logic              out_valid;
  logic [LINE_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              overrun;
  logic [AW:0]       count;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  line_store_server #(.LINE_W(LINE_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .start(start),
    .readLine(readLine), .line(line), .line_valid(line_valid), .last_line(last_line),
    .write(write), .wdata(wdata), .finish(finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .overrun(overrun), .count(count)
  );

  function automatic outs_t o(input logic ldr, input logic st, input logic lv,
                              input logic [LINE_W-1:0] ln, input logic ll,
                              input logic ov, input logic [LINE_W-1:0] od,
                              input logic ol, input logic orun, input logic [AW:0] cnt);
    outs_t r;
    r.ld_ready = ldr; r.start = st; r.line_valid = lv; r.line = ln; r.last_line = ll;
    r.out_valid = ov; r.out_data = od; r.out_last = ol; r.overrun = orun; r.count = cnt;
    return r;
  endfunction

  task automatic add(input logic lv, input logic [LINE_W-1:0] ld, input logic ll,
                     input logic rd, input logic wr, input logic [LINE_W-1:0] wd,
                     input logic fin, input logic ordy, input outs_t e);
    vec_t v;
    v.ld_valid = lv; v.ld_data = ld; v.ld_last = ll; v.rd = rd; v.wr = wr;
    v.wdata = wd; v.fin = fin; v.ordy = ordy; v.exp = e;
    vq.push_back(v);
  endtask

  // Data fields only matter when their valid is expected high.
  task automatic check(input string name, input outs_t e);
    outs_t a;
    a.ld_ready = ld_ready; a.start = start; a.line_valid = line_valid;
    a.line = e.line_valid ? line : '0;
    a.last_line = last_line; a.out_valid = out_valid;
    a.out_data = e.out_valid ? out_data : '0;
    a.out_last = out_last; a.overrun = overrun; a.count = count;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got ldr=%b st=%b lv=%b line=%h ll=%b ov=%b od=%h ol=%b orun=%b cnt=%0d, expected ldr=%b st=%b lv=%b line=%h ll=%b ov=%b od=%h ol=%b orun=%b cnt=%0d",
               name, a.ld_ready, a.start, a.line_valid, a.line, a.last_line, a.out_valid,
               a.out_data, a.out_last, a.overrun, a.count,
               e.ld_ready, e.start, e.line_valid, e.line, e.last_line, e.out_valid,
               e.out_data, e.out_last, e.overrun, e.count);
    end
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_data = '0; ld_last = 0; readLine = 0; write = 0;
    wdata = '0; finish = 0; out_ready = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      ld_valid = vq[i].ld_valid; ld_data = vq[i].ld_data; ld_last = vq[i].ld_last;
      readLine = vq[i].rd; write = vq[i].wr; wdata = vq[i].wdata;
      finish = vq[i].fin; out_ready = vq[i].ordy;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tag, i), vq[i].exp);
    end
    idle_inputs();
    vq.delete();
  endtask

  // One clocked beat with the given inputs, then check the result.
  task automatic beat(input string name, input logic lv, input logic [LINE_W-1:0] ld,
                      input logic ll, input logic rd, input logic wr,
                      input logic [LINE_W-1:0] wd, input outs_t e);
    ld_valid = lv; ld_data = ld; ld_last = ll; readLine = rd; write = wr; wdata = wd;
    @(posedge clk); #1;
    check(name, e);
    idle_inputs();
  endtask

  // Reset asserted between clock edges; its effect must be immediate.
  task automatic async_reset(input string name);
    #3;
    rst = 1'b0;
    #1;
    check(name, o(1,0,0,0,0, 0,0,0, 0,0));
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", o(1,0,0,0,0, 0,0,0, 0,0));
    rst = 1'b1;

    // Block 1: five lines, five reads, one excess read, full dump.
    add(1,25'h1,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,1));
    add(1,25'h2,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,2));
    add(1,25'h3,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,3));
    add(1,25'h4,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,4));
    add(1,25'h5,1, 0,0,0, 0,0, o(0,1,0,0,0, 0,0,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h1,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h2,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h3,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h4,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h5,1, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,0,0,0, 0,0,0, 1,5));
    add(0,0,0,     0,0,0, 1,0, o(0,0,0,0,0, 1,25'h1,0, 1,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h2,0, 1,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h3,0, 1,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h4,0, 1,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h5,1, 1,5));
    add(0,0,0,     0,0,0, 0,1, o(1,0,0,0,0, 0,0,0, 1,0));
    run_table("blk1");

    async_reset("reset_clears_overrun");

    // Block 2: read/write interleave, then dump with a stalling consumer.
    add(1,25'h1,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,1));
    add(1,25'h2,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,2));
    add(1,25'h3,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,3));
    add(1,25'h4,0, 0,0,0, 0,0, o(1,0,0,0,0, 0,0,0, 0,4));
    add(1,25'h5,1, 0,0,0, 0,0, o(0,1,0,0,0, 0,0,0, 0,5));
    add(0,0,0,     1,0,0, 0,0, o(0,0,1,25'h1,0, 0,0,0, 0,5));
    add(0,0,0,     1,1,25'h1FFFFFF, 0,0, o(0,0,1,25'h2,0, 0,0,0, 0,5));
    add(0,0,0,     0,0,0, 1,0, o(0,0,0,0,0, 1,25'h1FFFFFF,0, 0,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h2,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h2,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h2,0, 0,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h3,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h3,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h3,0, 0,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h4,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h4,0, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h4,0, 0,5));
    add(0,0,0,     0,0,0, 0,1, o(0,0,0,0,0, 1,25'h5,1, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h5,1, 0,5));
    add(0,0,0,     0,0,0, 0,0, o(0,0,0,0,0, 1,25'h5,1, 0,5));
    add(0,0,0,     0,0,0, 0,1, o(1,0,0,0,0, 0,0,0, 0,0));
    run_table("blk2");

    // Full-depth load with no ld_last: forced into SERVE with overrun.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < DEPTH - 1)
        beat($sformatf("fill[%0d]", i), 1, LINE_W'(100 + i), 0, 0, 0, '0,
             o(1,0,0,0,0, 0,0,0, 0,(AW+1)'(i + 1)));
      else
        beat($sformatf("fill[%0d]", i), 1, LINE_W'(100 + i), 0, 0, 0, '0,
             o(0,1,0,0,0, 0,0,0, 1,(AW+1)'(DEPTH)));
    end
    for (int i = 0; i < DEPTH; i++) begin
      beat($sformatf("fullread[%0d]", i), 0, '0, 0, 1, 0, '0,
           o(0,0,1,LINE_W'(100 + i),(i == DEPTH - 1), 0,0,0, 1,(AW+1)'(DEPTH)));
    end

    async_reset("reset_after_full");

    // Mid-SERVE reset after two reads, then a fresh block from line 0.
    beat("b3_ld0", 1, 25'hA, 0, 0, 0, '0, o(1,0,0,0,0, 0,0,0, 0,1));
    beat("b3_ld1", 1, 25'hB, 0, 0, 0, '0, o(1,0,0,0,0, 0,0,0, 0,2));
    beat("b3_ld2", 1, 25'hC, 1, 0, 0, '0, o(0,1,0,0,0, 0,0,0, 0,3));
    beat("b3_rd0", 0, '0, 0, 1, 0, '0, o(0,0,1,25'hA,0, 0,0,0, 0,3));
    beat("b3_rd1", 0, '0, 0, 1, 0, '0, o(0,0,1,25'hB,0, 0,0,0, 0,3));
    async_reset("reset_mid_serve");
    beat("b4_ld0", 1, 25'h11, 0, 0, 0, '0, o(1,0,0,0,0, 0,0,0, 0,1));
    beat("b4_ld1", 1, 25'h22, 0, 0, 0, '0, o(1,0,0,0,0, 0,0,0, 0,2));
    beat("b4_ld2", 1, 25'h33, 1, 0, 0, '0, o(0,1,0,0,0, 0,0,0, 0,3));
    beat("b4_early_wr", 0, '0, 0, 0, 1, 25'h0ABCDEF, o(0,0,0,0,0, 0,0,0, 1,3));
    beat("b4_rd0", 0, '0, 0, 1, 0, '0, o(0,0,1,25'h11,0, 0,0,0, 1,3));
    beat("b4_rd1", 0, '0, 0, 1, 0, '0, o(0,0,1,25'h22,0, 0,0,0, 1,3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_store_server.md
# line_store_server

Line-buffer responder on the far side of the slice controller's line-read/write interface. It accepts a block of 25-bit lines (one 5x5 slice per line) from an upstream loader. It then serves the controller's `readLine` requests one line per request and accepts in-place write-back of the processed line. When the controller finishes, it streams the updated block out to the downstream consumer. It owns line counting and end-of-block signalling, so the controller does not need its own Y-dimension counter.

## Interface
- `LINE_W`, default 25: line width in bits (5x5 slice).
- `DEPTH`, default 32: maximum lines per block.
- `AW`, default 5: address width, with DEPTH = 2^AW.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  upstream line valid.
- `ld_data`  in  LINE_W  upstream line.
- `ld_last`  in  1  marks final upstream line of the block.
- `ld_ready`  out  1  buffer can accept an upstream line.
- `start`  out  1  one-cycle pulse: block loaded, controller may begin.
- `readLine`  in  1  controller requests next line.
- `line`  out  LINE_W  line returned to controller.
- `line_valid`  out  1  `line` valid (one cycle per request).
- `last_line`  out  1  qualifies `line_valid`: this is the final line of the block.
- `write`  in  1  write `wdata` back over the most recently delivered line.
- `wdata`  in  LINE_W  write-back data.
- `finish`  in  1  controller done; begin output dump.
- `out_valid`  out  1  downstream line valid.
- `out_data`  out  LINE_W  downstream line.
- `out_last`  out  1  final downstream line.
- `out_ready`  in  1  downstream accepts.
- `overrun`  out  1  sticky protocol-error flag.
- `count`  out  AW+1  number of lines in the current block.

## Operation
- FSM states: IDLE, LOAD, SERVE, DUMP.
- **IDLE**
  - `ld_ready`=1.
  - A beat with `ld_valid`=1 writes `mem[0]`, sets `count`=1 and moves to LOAD. If `ld_last` is also high, it moves directly to SERVE.
- **LOAD**
  - `ld_ready`=1.
  - Each accepted beat writes `mem[count]` and increments `count`.
  - A beat with `ld_last`=1 moves to SERVE.
  - If a beat fills location DEPTH-1 without `ld_last`, it is treated as last and `overrun` is set.
- **Entry to SERVE**
  - `start` pulses for the first cycle in SERVE.
  - Read pointer `rp`=0.
- **SERVE**
  - `readLine` sampled high with `rp`<`count`: the next cycle drives `line`=`mem[rp]` and `line_valid`=1. `last_line`=1 when `rp`=`count`-1.
  - Each served request records `wp`=`rp` and increments `rp`.
  - `readLine` with `rp`=`count`: no `line_valid`, and `overrun` is set.
  - `write`=1: `mem[wp]`<=`wdata`. A `write` before any line has been delivered is ignored and sets `overrun`.
  - `readLine` and `write` in the same cycle are legal: the write targets the previous line and the read returns the next one.
  - `finish`=1 moves to DUMP, output pointer `op`=0. A concurrent `write` is still committed.
- **DUMP**
  - Drives `out_data`=`mem[op]` and `out_valid`=1. `out_last`=1 when `op`=`count`-1.
  - `op` advances only on `out_valid`&`out_ready`.
  - The last accepted beat returns the FSM to IDLE and clears `count`.
  - `readLine` and `write` are ignored outside SERVE. Load inputs are ignored (`ld_ready`=0) in SERVE and DUMP.
- **Reset** (`rst`=0, any time, including mid-block)
  - State IDLE.
  - All outputs 0 except `ld_ready`=1.
  - `count`, `rp`, `wp`, `op` = 0; `overrun` cleared.
  - Memory contents unspecified.

## Timing
- Load: one line per cycle.
- `start`: asserted in the cycle after the `ld_last` beat is accepted.
- Read latency: exactly 1 cycle from `readLine` sample to `line_valid`. Back-to-back requests give one line per cycle.
- Write-back: takes effect at the sampling edge. A `readLine` of the same address issued later sees the new data.
- Dump:
  - First `out_valid` appears in the cycle after `finish` is sampled.
  - `out_data` is held stable while `out_valid`&~`out_ready`.
  - Throughput is one line per cycle with `out_ready` tied high.
- `count` is stable from `start` until return to IDLE.

## Test plan
- Load 5 lines 0x0000001..0x0000005 with `ld_last` on the 5th -> `start` pulses once, one cycle later, and `count`=5.
- In SERVE, hold `readLine` for 5 cycles -> `line` = 1,2,3,4,5 on consecutive cycles with `line_valid`=1 each. `last_line` is high only with 5. A 6th request gives no `line_valid` and sets `overrun`=1.
- Interleave: read line 0, then `write` 0x1FFFFFF while reading line 1, then `finish` -> dump yields 0x1FFFFFF, 2, 3, 4, 5 with `out_last` on 5.
- Dump with `out_ready` toggling 1,0,0,1,... -> no line dropped or duplicated, and `out_data` is stable during stalls.
- Load DEPTH lines without `ld_last` -> SERVE entered after line DEPTH, `overrun`=1, `count`=DEPTH.
- Assert `rst`=0 mid-SERVE after 2 reads -> outputs zero, `ld_ready`=1 asynchronously. A new 3-line block then loads and reads from line 0.
